// File: rtl/calc_pkg.sv
// Shared calculator definitions: widths, BCD conversion FSM states, display codes.
package calc_pkg;

   localparam int unsigned VALUE_W    = 32;
   localparam int unsigned BCD_DIGITS = 10;
   localparam int unsigned NIB_W      = 4;
   localparam int unsigned BCD_W      = BCD_DIGITS * NIB_W;
   localparam int unsigned CNT_W      = 5;
   localparam int unsigned DCNT_W     = 4;

   // Non-decimal nibble codes the segment driver renders as '-' and blank.
   localparam logic [NIB_W-1:0] BCD_MINUS = 4'hA;
   localparam logic [NIB_W-1:0] BCD_BLANK = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_FINISH = 2'd2
   } bcd_state_e;

   // Converted result as presented to the display path.
   typedef struct packed {
      logic              sign;
      logic [BCD_W-1:0]  bcd;
      logic [DCNT_W-1:0] digit_cnt;
      logic              ovf;
   } bcd_result_t;

   // Significant-digit count: position of the top nonzero nibble + 1, minimum 1.
   function automatic logic [DCNT_W-1:0] msd_count(input logic [BCD_W-1:0] b);
      logic [DCNT_W-1:0] cnt;
      cnt = DCNT_W'(1);
      for (int i = 0; i < int'(BCD_DIGITS); i++) begin
         if (b[i*NIB_W +: NIB_W] != '0) cnt = DCNT_W'(i + 1);
      end
      return cnt;
   endfunction

endpackage

// File: rtl/result_bcd_encoder_if.sv
// Start/done handshake and result bus between calculator core and BCD encoder.
interface result_bcd_encoder_if;
   import calc_pkg::*;

   logic                start;
   logic [VALUE_W-1:0]  value;
   logic                busy;
   logic                done;
   logic                sign;
   logic [BCD_W-1:0]    bcd;
   logic [DCNT_W-1:0]   digit_cnt;
   logic                ovf;

   // Requester side: issues conversions, consumes results.
   modport master (
      output start, value,
      input  busy, done, sign, bcd, digit_cnt, ovf
   );

   // Encoder side.
   modport slave (
      input  start, value,
      output busy, done, sign, bcd, digit_cnt, ovf
   );
endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD nibble when it is 5 or more.
module bcd_digit_adj
   import calc_pkg::*;
(
   input  logic [NIB_W-1:0] nib_in,
   output logic [NIB_W-1:0] nib_out_c
);

   // Pre-shift correction so the doubled digit carries correctly into the next nibble.
   always_comb begin
      nib_out_c = nib_in;
      if (nib_in >= NIB_W'(5)) nib_out_c = nib_in + NIB_W'(3);
   end

endmodule

// File: rtl/result_bcd_encoder.sv
// Signed 32-bit result to sign + 10-digit packed BCD, shift-and-add-3, 33-cycle latency.
module result_bcd_encoder
   import calc_pkg::*;
#(
   parameter int unsigned DISP_DIGITS = 4
) (
   input  logic                 clock_50m,
   input  logic                 rst,
   result_bcd_encoder_if.slave  bus
);

   bcd_state_e         state_q, state_n;
   logic [VALUE_W-1:0] mag_q, mag_n;
   logic [BCD_W-1:0]   work_q, work_n;
   logic [CNT_W-1:0]   cnt_q, cnt_n;
   logic               sign_lat_q, sign_lat_n;
   logic               busy_q, busy_n;
   logic               done_q, done_n;
   bcd_result_t        res_q, res_n;
   logic [BCD_W-1:0]   adj_c;

   // One corrector per working digit.
   for (genvar g = 0; g < int'(BCD_DIGITS); g++) begin : g_adj
      bcd_digit_adj u_adj (
         .nib_in    (work_q[g*NIB_W +: NIB_W]),
         .nib_out_c (adj_c[g*NIB_W +: NIB_W])
      );
   end

   // Next-state and next-register values; everything holds unless a state acts on it.
   always_comb begin
      state_n    = state_q;
      mag_n      = mag_q;
      work_n     = work_q;
      cnt_n      = cnt_q;
      sign_lat_n = sign_lat_q;
      busy_n     = busy_q;
      done_n     = 1'b0;
      res_n      = res_q;

      unique case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               // Magnitude as unsigned: -2^31 maps to 0x8000_0000.
               sign_lat_n = bus.value[VALUE_W-1];
               mag_n      = bus.value[VALUE_W-1] ? (~bus.value + VALUE_W'(1)) : bus.value;
               work_n     = '0;
               cnt_n      = '0;
               busy_n     = 1'b1;
               state_n    = ST_SHIFT;
            end
         end

         ST_SHIFT: begin
            {work_n, mag_n} = {adj_c, mag_q} << 1;
            cnt_n           = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(VALUE_W - 1)) state_n = ST_FINISH;
         end

         ST_FINISH: begin
            res_n.bcd       = work_q;
            res_n.sign      = sign_lat_q;
            res_n.digit_cnt = msd_count(work_q);
            res_n.ovf       = 32'(msd_count(work_q)) > 32'(DISP_DIGITS);
            done_n          = 1'b1;
            busy_n          = 1'b0;
            state_n         = ST_IDLE;
         end

         default: begin
            busy_n  = 1'b0;
            state_n = ST_IDLE;
         end
      endcase
   end

   // State and data registers with synchronous active-low reset.
   always_ff @(posedge clock_50m) begin
      if (!rst) begin
         state_q         <= ST_IDLE;
         mag_q           <= '0;
         work_q          <= '0;
         cnt_q           <= '0;
         sign_lat_q      <= 1'b0;
         busy_q          <= 1'b0;
         done_q          <= 1'b0;
         res_q.sign      <= 1'b0;
         res_q.bcd       <= '0;
         res_q.digit_cnt <= DCNT_W'(1);
         res_q.ovf       <= 1'b0;
      end else begin
         state_q    <= state_n;
         mag_q      <= mag_n;
         work_q     <= work_n;
         cnt_q      <= cnt_n;
         sign_lat_q <= sign_lat_n;
         busy_q     <= busy_n;
         done_q     <= done_n;
         res_q      <= res_n;
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.sign      = res_q.sign;
   assign bus.bcd       = res_q.bcd;
   assign bus.digit_cnt = res_q.digit_cnt;
   assign bus.ovf       = res_q.ovf;

endmodule

// File: tb/tb_result_bcd_encoder.sv
// Directed vectors plus handshake corner cases for result_bcd_encoder.
module tb_result_bcd_encoder;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   result_bcd_encoder_if bus ();

   result_bcd_encoder #(.DISP_DIGITS(4)) dut (
      .clock_50m (clk),
      .rst       (rst),
      .bus       (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] value;
      logic [39:0] bcd;
      logic        sign;
      logic [3:0]  dcnt;
      logic        ovf;
   } vec_t;

   vec_t vecs[11];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Present value with a one-cycle start; returns just after the accepting edge.
   task automatic start_conv(input logic [31:0] v);
      @(negedge clk);
      bus.start = 1'b1;
      bus.value = v;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.value = 32'hDEAD_BEEF;
   endtask

   // Count edges to done (bounded); also record whether busy ever dropped early.
   task automatic wait_done(output int lat, output bit busy_bad);
      lat      = -1;
      busy_bad = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         if (bus.done) begin
            lat = i;
            break;
         end
         if (!bus.busy) busy_bad = 1'b1;
      end
   endtask

   task automatic check_result(input string tag, input logic [39:0] b, input logic s,
                               input logic [3:0] dc, input logic o);
      check({tag, ".bcd"},  64'(bus.bcd), 64'(b));
      check({tag, ".sign"}, 64'(bus.sign), 64'(s));
      check({tag, ".dcnt"}, 64'(bus.digit_cnt), 64'(dc));
      check({tag, ".ovf"},  64'(bus.ovf), 64'(o));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, ".busy"}, 64'(bus.busy), 64'(0));
      check({tag, ".done"}, 64'(bus.done), 64'(0));
      check_result(tag, 40'h0, 1'b0, 4'd1, 1'b0);
   endtask

   initial begin
      int lat;
      bit busy_bad;
      int ndone;

      checks   = 0;
      failures = 0;

      vecs[0]  = '{32'd0,           40'h00_0000_0000, 1'b0, 4'd1,  1'b0};
      vecs[1]  = '{-32'sd1234,      40'h00_0000_1234, 1'b1, 4'd4,  1'b0};
      vecs[2]  = '{32'd12345,       40'h00_0001_2345, 1'b0, 4'd5,  1'b1};
      vecs[3]  = '{32'h8000_0000,   40'h21_4748_3648, 1'b1, 4'd10, 1'b1};
      vecs[4]  = '{32'h7FFF_FFFF,   40'h21_4748_3647, 1'b0, 4'd10, 1'b1};
      vecs[5]  = '{32'd9999,        40'h00_0000_9999, 1'b0, 4'd4,  1'b0};
      vecs[6]  = '{32'd10000,       40'h00_0001_0000, 1'b0, 4'd5,  1'b1};
      vecs[7]  = '{32'd1,           40'h00_0000_0001, 1'b0, 4'd1,  1'b0};
      vecs[8]  = '{32'hFFFF_FFFF,   40'h00_0000_0001, 1'b1, 4'd1,  1'b0};
      vecs[9]  = '{32'd100,         40'h00_0000_0100, 1'b0, 4'd3,  1'b0};
      vecs[10] = '{-32'sd1000000000, 40'h10_0000_0000, 1'b1, 4'd10, 1'b1};

      bus.start = 1'b0;
      bus.value = 32'h0;
      rst       = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      @(negedge clk);
      rst = 1'b1;

      // Table-driven conversions with latency and handshake checks.
      foreach (vecs[k]) begin
         start_conv(vecs[k].value);
         check($sformatf("v%0d.busy_e0", k), 64'(bus.busy), 64'(1));
         wait_done(lat, busy_bad);
         check($sformatf("v%0d.latency", k), 64'(lat), 64'(33));
         check($sformatf("v%0d.busy_hold", k), 64'(busy_bad), 64'(0));
         check($sformatf("v%0d.busy_done", k), 64'(bus.busy), 64'(0));
         check_result($sformatf("v%0d", k), vecs[k].bcd, vecs[k].sign, vecs[k].dcnt, vecs[k].ovf);
         @(posedge clk);
         #1;
         check($sformatf("v%0d.done_pulse", k), 64'(bus.done), 64'(0));
         check_result($sformatf("v%0d.hold", k), vecs[k].bcd, vecs[k].sign, vecs[k].dcnt, vecs[k].ovf);
      end

      // Start re-pulsed mid-conversion is ignored; start in the done cycle is taken.
      start_conv(32'd99);
      ndone = 0;
      for (int i = 1; i <= 33; i++) begin
         @(posedge clk);
         #1;
         if (bus.done) ndone++;
         bus.start = (i == 4 || i == 19);
         bus.value = 32'd555;
      end
      check("repulse.done_at_33", 64'(bus.done), 64'(1));
      check("repulse.done_count", 64'(ndone), 64'(1));
      check("repulse.bcd", 64'(bus.bcd), 64'h99);
      bus.start = 1'b1;
      bus.value = 32'd7;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.value = 32'h0;
      check("b2b.busy_e0", 64'(bus.busy), 64'(1));
      wait_done(lat, busy_bad);
      check("b2b.latency", 64'(lat), 64'(33));
      check_result("b2b", 40'h7, 1'b0, 4'd1, 1'b0);

      // Reset mid-SHIFT aborts without a done; next conversion is normal.
      start_conv(32'd12345);
      repeat (16) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_reset_outputs("midrst");
      @(negedge clk);
      rst = 1'b1;
      ndone = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (bus.done || bus.busy) ndone++;
      end
      check("midrst.no_done", 64'(ndone), 64'(0));
      start_conv(-32'sd5);
      wait_done(lat, busy_bad);
      check("after_rst.latency", 64'(lat), 64'(33));
      check_result("after_rst", 40'h5, 1'b1, 4'd1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/result_bcd_encoder.md
# result_bcd_encoder

Converts a signed 32-bit two's-complement calculator result into sign plus 10 packed BCD digits with a start/done handshake, for the seven-segment path. It performs the inverse of the key-entry accumulation (`buffer*10 + digit`): binary back to decimal digits. It sits between the `calculate` result (`ans`) and `segment_driver`, and runs on the keypad/calculator clock domain. It also reports the significant-digit count and whether the value exceeds the physical display width.

## Interface
- `DISP_DIGITS`, default 4: number of physical FND digits; sets the `ovf` threshold.
- `clock_50m`  in  1  single clock; all flops on its rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `start`  in  1  request a conversion of `value`; sampled only in IDLE.
- `value`  in  32  signed two's-complement result, captured on the accepting edge.
- `busy`  out  1  conversion in progress.
- `done`  out  1  one-cycle pulse when the result outputs are updated.
- `sign`  out  1  1 = value was negative.
- `bcd`  out  40  10 BCD digits, `[3:0]` = units, `[39:36]` = 10^9.
- `digit_cnt`  out  4  significant digits, range 1..10.
- `ovf`  out  1  `digit_cnt > DISP_DIGITS`.

## Operation
- FSM states: IDLE, SHIFT, FINISH.
- IDLE: on `start`=1, latch `sign = value[31]` and the 32-bit unsigned magnitude `mag = sign ? -value : value`. For -2^31 the magnitude is 0x8000_0000 (no overflow, unsigned interpretation). Clear the 40-bit working BCD register and the 5-bit shift counter, then go to SHIFT.
- SHIFT: each cycle, add 3 to every working nibble ≥ 5, then shift {bcd_work, mag} left by 1 (the MSB of `mag` enters `bcd_work[0]`). Increment the counter. After the 32nd shift, go to FINISH.
- FINISH:
  - Copy the working BCD to `bcd` and the latched sign to `sign`.
  - `digit_cnt` = index of the most significant nonzero nibble + 1, or 1 if all nibbles are zero.
  - Compute `ovf`, pulse `done`, return to IDLE.
- Outputs `bcd`, `sign`, `digit_cnt`, `ovf` change only in FINISH and otherwise hold their last values.
- `start` while `busy`: ignored, not queued.
- `value` is not required to stay stable after the accepting edge.
- Zero is never negative: `sign` = 0 for input 0.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `sign`=0, `bcd`=0, `digit_cnt`=1, `ovf`=0. All internal registers are cleared.
- Start accepted at edge E0:
  - `busy`=1 from E0 through E32.
  - At E33 (FINISH), outputs are updated, `done`=1 for exactly one cycle, and `busy`=0 in the same cycle.
  - Latency is 33 cycles from start edge to done.
- `start` high in the `done` cycle is accepted, because the FSM is already IDLE. Back-to-back throughput is one conversion per 33 cycles.
- `rst`=0 at any edge, including mid-SHIFT, forces reset values on that edge. There is no `done` for an aborted conversion.
- A held `start` re-triggers a new conversion every 33 cycles. Upstream must present a single-cycle pulse for a single conversion.

## Structure
- Shared package `calc_pkg`:
  - `BCD_DIGITS` = 10, `VALUE_W` = 32.
  - FSM state typedef/localparams.
  - BCD nibble width.
  - `BCD_MINUS`/blank codes used later by `segment_driver`.
- One combinational sub-module `bcd_digit_adj`: 4-bit in, 4-bit out, add-3 when ≥ 5. Instantiate it 10× in a generate loop.
- Counter, FSM and output registers live in the top of this block. No other sub-modules.

## Test plan
- Reset, then `value`=0, `start` pulse → `done` exactly 33 cycles later; `bcd`=0x00_0000_0000, `sign`=0, `digit_cnt`=1, `ovf`=0.
- `value`=-1234 → `bcd`=0x00_0000_1234, `sign`=1, `digit_cnt`=4, `ovf`=0.
- `value`=12345 → `bcd`=0x00_0001_2345, `sign`=0, `digit_cnt`=5, `ovf`=1.
- Extremes:
  - `value`=0x8000_0000 → `bcd`=0x21_4748_3648, `sign`=1, `digit_cnt`=10.
  - `value`=0x7FFF_FFFF → `bcd`=0x21_4748_3647, `sign`=0.
- `start` re-pulsed at cycles 5 and 20 of a conversion of 99 → ignored: one `done`, `bcd`=0x99. Then `start` in the `done` cycle with 7 → second `done` 33 cycles later, `bcd`=0x7.
- `rst`=0 at SHIFT cycle 16 → all outputs at reset values next cycle and no `done`. A following conversion of -5 completes normally: `bcd`=0x5, `sign`=1.
